// File: rtl/nibble_match_detector.sv
// Watches a 4-bit shift register's parallel output once per slow-strobe and flags a run of PERSIST
// consecutive matches against a programmable nibble. Define NIBBLE_MATCH_SAT_EN to saturate match_cnt.
module nibble_match_detector #(
  parameter int unsigned PERSIST = 2,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             clk2,
  input  logic [3:0]       q_in,
  input  logic [3:0]       pattern,
  output logic [3:0]       sample,
  output logic             match,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned RunW = $clog2(PERSIST + 1);
  localparam logic [RunW-1:0] RunMax = RunW'(PERSIST);

  typedef enum logic [1:0] {StIdle, StCheck, StLocked} state_e;

  logic             s1_q, s2_q, s3_q;
  logic [3:0]       sample_q, sample_d;
  logic [RunW-1:0]  run_q, run_d, run_sat;
  logic [RunW:0]    run_p1;
  state_e           state_q, state_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             strobe, hit, lock_ok;

  assign strobe  = s2_q & ~s3_q;
  assign hit     = (q_in == pattern);
  assign run_p1  = {1'b0, run_q} + (RunW + 1)'(1);
  assign lock_ok = (run_p1 >= (RunW + 1)'(PERSIST));
  assign run_sat = (run_q == RunMax) ? RunMax : run_q + RunW'(1);

`ifdef NIBBLE_MATCH_SAT_EN
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
`else
  assign cnt_inc = cnt_q + CNT_W'(1);
`endif

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    sample_d = sample_q;
    pulse_d  = 1'b0;
    cnt_d    = cnt_q;
    if (strobe) begin
      sample_d = q_in;
      if (hit) begin
        run_d = run_sat;
        unique case (state_q)
          StIdle, StCheck: begin
            if (lock_ok) begin
              state_d = StLocked;
              pulse_d = 1'b1;
              cnt_d   = cnt_inc;
            end else begin
              state_d = StCheck;
            end
          end
          StLocked: state_d = StLocked;
          default:  state_d = StIdle;
        endcase
      end else begin
        run_d   = '0;
        state_d = StCheck;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      sample_q <= '0;
      run_q    <= '0;
      state_q  <= StIdle;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= clk2;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      sample_q <= sample_d;
      run_q    <= run_d;
      state_q  <= state_d;
      pulse_q  <= pulse_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sample      = sample_q;
  assign match       = (state_q == StLocked);
  assign match_pulse = pulse_q;
  assign match_cnt   = cnt_q;

endmodule

// File: tb/tb_nibble_match_detector.sv
// Scoreboard bench: two instances (PERSIST=2/CNT_W=2 and PERSIST=1/CNT_W=8) share stimulus and
// are checked against a streak-counting reference model.
module tb_nibble_match_detector;

  localparam int PA = 2;
  localparam int WA = 2;
  localparam int PB = 1;
  localparam int WB = 8;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          clk2 = 1'b0;
  logic [3:0]    q_in = 4'h0;
  logic [3:0]    pattern = 4'h0;
  logic [3:0]    sample_a, sample_b;
  logic          match_a, match_b, pulse_a, pulse_b;
  logic [WA-1:0] cnt_a;
  logic [WB-1:0] cnt_b;

  nibble_match_detector #(.PERSIST(PA), .CNT_W(WA)) dut_a (
    .clk(clk), .clr(clr), .clk2(clk2), .q_in(q_in), .pattern(pattern),
    .sample(sample_a), .match(match_a), .match_pulse(pulse_a), .match_cnt(cnt_a)
  );

  nibble_match_detector #(.PERSIST(PB), .CNT_W(WB)) dut_b (
    .clk(clk), .clr(clr), .clk2(clk2), .q_in(q_in), .pattern(pattern),
    .sample(sample_b), .match(match_b), .match_pulse(pulse_b), .match_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint     due;
    logic [3:0] sample;
    bit         match [2];
    bit         pulse [2];
    int         cnt   [2];
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: length of the current matching streak, lock = streak reaches PERSIST.
  int         streak [2];
  int         ecnt   [2];
  logic [3:0] esample;

  task automatic cmp(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      streak[i] = 0;
      ecnt[i]   = 0;
    end
    esample = 4'h0;
  endtask

  task automatic model_step(input logic [3:0] qv, input logic [3:0] pat, output exp_t e);
    int p, w, maxc;
    bit was, now;
    esample  = qv;
    e.sample = qv;
    for (int i = 0; i < 2; i++) begin
      p    = (i == 0) ? PA : PB;
      w    = (i == 0) ? WA : WB;
      maxc = (1 << w) - 1;
      was  = (streak[i] >= p);
      streak[i] = (qv == pat) ? streak[i] + 1 : 0;
      now  = (streak[i] >= p);
      if (now && !was) begin
`ifdef NIBBLE_MATCH_SAT_EN
        ecnt[i] = (ecnt[i] == maxc) ? maxc : ecnt[i] + 1;
`else
        ecnt[i] = (ecnt[i] + 1) % (maxc + 1);
`endif
      end
      e.match[i] = now;
      e.pulse[i] = now && !was;
      e.cnt[i]   = ecnt[i];
    end
  endtask

  task automatic push_exp(input logic [3:0] qv, input longint due);
    exp_t e, e2;
    model_step(qv, pattern, e);
    e.due = due;
    sb.push_back(e);
    e2 = e;
    e2.due = due + 1;
    e2.pulse[0] = 1'b0;
    e2.pulse[1] = 1'b0;
    sb.push_back(e2);
  endtask

  // clk2 high 3 cycles, low 3 cycles; the strobe is consumed on the 3rd edge after the rise.
  task automatic do_strobe(input logic [3:0] qv);
    @(negedge clk);
    q_in = qv;
    clk2 = 1'b1;
    push_exp(qv, cyc + 3);
    repeat (3) @(negedge clk);
    clk2 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    cmp({tag, "_sample_a"}, sample_a, 0);
    cmp({tag, "_sample_b"}, sample_b, 0);
    cmp({tag, "_match_a"}, match_a, 0);
    cmp({tag, "_match_b"}, match_b, 0);
    cmp({tag, "_pulse_a"}, pulse_a, 0);
    cmp({tag, "_pulse_b"}, pulse_b, 0);
    cmp({tag, "_cnt_a"}, cnt_a, 0);
    cmp({tag, "_cnt_b"}, cnt_b, 0);
  endtask

  // Monitor: compares DUT outputs when a scoreboard entry falls due.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due < cyc) begin
      cmp("sb_late_entry", int'(cyc), int'(sb[0].due));
      void'(sb.pop_front());
    end else if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_t e;
      e = sb.pop_front();
      cmp("sample_a", sample_a, e.sample);
      cmp("sample_b", sample_b, e.sample);
      cmp("match_a", match_a, e.match[0]);
      cmp("match_b", match_b, e.match[1]);
      cmp("pulse_a", pulse_a, e.pulse[0]);
      cmp("pulse_b", pulse_b, e.pulse[1]);
      cmp("cnt_a", cnt_a, e.cnt[0]);
      cmp("cnt_b", cnt_b, e.cnt[1]);
    end
  end

  initial begin
    model_reset();
    repeat (5) @(negedge clk);
    check_idle("in_reset");
    clr = 1'b0;
    repeat (4) @(negedge clk);
    check_idle("post_reset");

    // PERSIST=1 instance locks straight from idle.
    pattern = 4'h5;
    do_strobe(4'h5);

    // Shift in ones, break, relock, then cycle the narrow counter through its limit.
    pattern = 4'hF;
    do_strobe(4'h1);
    do_strobe(4'h3);
    do_strobe(4'h7);
    do_strobe(4'hF);
    do_strobe(4'hF);
    do_strobe(4'hE);
    do_strobe(4'hF);
    do_strobe(4'hF);
    for (int k = 0; k < 3; k++) begin
      do_strobe(4'hE);
      do_strobe(4'hF);
      do_strobe(4'hF);
    end

    // Randomized: mostly matching nibbles, occasional pattern change.
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) == 0) pattern = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) do_strobe(pattern);
      else do_strobe(4'($urandom_range(0, 15)));
    end

    // Reset asserted after the rise but before the strobe is consumed.
    pattern = 4'hA;
    @(negedge clk);
    q_in = 4'hA;
    clk2 = 1'b1;
    @(negedge clk);
    clr = 1'b1;
    #1;
    check_idle("midrun_clr");
    @(negedge clk);
    clk2 = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    check_idle("midrun_after");
    do_strobe(4'hA);
    do_strobe(4'hA);

    // clk2 held high through release yields one strobe sampling the reset value of q_in.
    @(negedge clk);
    clr  = 1'b1;
    clk2 = 1'b1;
    q_in = 4'h0;
    pattern = 4'h0;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    model_reset();
    push_exp(4'h0, cyc + 3);
    repeat (5) @(negedge clk);
    clk2 = 1'b0;
    repeat (3) @(negedge clk);
    do_strobe(4'h0);
    do_strobe(4'h3);

    repeat (4) @(negedge clk);
    cmp("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
